imem_boot_loader: RTL and testbench

- Upstream of the single-cycle 32-bit RISC CPU.
- After system reset, receives a program as an 8-bit valid/ready byte stream and writes it word by word into instruction memory through its write port.
- Holds the CPU in reset (Cpu_rst) until a complete, checksum-verified image has been written.
- Drives the CPU's Rst input; the CPU fetches from address 0 once released.

---
 rtl/imem_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Function : Receives a framed program over a byte stream, writes it into
//            instruction memory and releases CPU reset on a good checksum.
// Revision : 1.0
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [7:0]            Byte_in,
  input  logic                  Byte_valid,
  output logic                  Byte_ready,
  output logic                  Imem_we,
  output logic [ADDR_WIDTH-1:0] Imem_addr,
  output logic [31:0]           Imem_wdata,
  output logic                  Cpu_rst,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_LO = 3'd1,
    S_HDR_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_cnt_lo;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_csum;
  logic [23:0] r_asm;
  logic        r_we;

  logic        w_start;
  logic        w_accept;
  logic [15:0] w_n;
  logic        w_hdr_bad;
  logic        w_last_word;
  logic        w_sum_ok;

  assign w_start     = Start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERROR));
  assign w_accept    = Byte_valid && Byte_ready;
  assign w_n         = {Byte_in, r_cnt_lo};
  assign w_hdr_bad   = (w_n == 16'd0) || ({1'b0, w_n} > c_MAX_WORDS);
  assign w_last_word = (r_byte_idx == 2'd3) && ((r_word_idx + 16'd1) == r_count);
  assign w_sum_ok    = (Byte_in == r_csum);

  // A write pulse that lines up with a reset edge must not reach memory.
  assign Imem_we     = r_we && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    Byte_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start) w_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        Byte_ready = 1'b1;
        if (w_accept) w_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        Byte_ready = 1'b1;
        if (w_accept) w_next = w_hdr_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        Byte_ready = 1'b1;
        if (w_accept && w_last_word) w_next = S_CHECK;
      end
      S_CHECK: begin
        Byte_ready = 1'b1;
        if (w_accept) w_next = w_sum_ok ? S_DONE : S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt_lo   <= 8'd0;
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_idx <= 2'd0;
      r_csum     <= 8'd0;
      r_asm      <= 24'd0;
      r_we       <= 1'b0;
      Imem_addr  <= '0;
      Imem_wdata <= 32'd0;
      Cpu_rst    <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        Busy       <= 1'b1;
        Done       <= 1'b0;
        Error      <= 1'b0;
        Cpu_rst    <= 1'b1;
        r_word_idx <= 16'd0;
        r_byte_idx <= 2'd0;
        r_csum     <= 8'd0;
      end else if (w_accept) begin
        case (r_state)
          S_HDR_LO: r_cnt_lo <= Byte_in;
          S_HDR_HI: begin
            r_count <= w_n;
            if (w_hdr_bad) begin
              Error   <= 1'b1;
              Busy    <= 1'b0;
              Cpu_rst <= 1'b1;
            end
          end
          S_DATA: begin
            r_csum     <= r_csum + Byte_in;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= Byte_in;
              2'd1: r_asm[15:8]  <= Byte_in;
              2'd2: r_asm[23:16] <= Byte_in;
              default: begin
                r_we       <= 1'b1;
                Imem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                Imem_wdata <= {Byte_in, r_asm};
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
          S_CHECK: begin
            Busy <= 1'b0;
            if (w_sum_ok) begin
              Done    <= 1'b1;
              Cpu_rst <= 1'b0;
            end else begin
              Error   <= 1'b1;
              Cpu_rst <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Function : Self-checking bench; frame-position reference model plus
//            directed frames and randomized frames with stalls.
// Revision : 1.0
// ============================================================================
module tb_imem_boot_loader;

  localparam int AW   = 8;
  localparam int MAXW = 256;

  logic          Clk = 1'b0;
  logic          Rst, Start, Byte_valid;
  logic [7:0]    Byte_in;
  logic          Byte_ready, Imem_we, Cpu_rst, Busy, Done, Error;
  logic [AW-1:0] Imem_addr;
  logic [31:0]   Imem_wdata;

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Byte_in(Byte_in),
    .Byte_valid(Byte_valid), .Byte_ready(Byte_ready), .Imem_we(Imem_we),
    .Imem_addr(Imem_addr), .Imem_wdata(Imem_wdata), .Cpu_rst(Cpu_rst),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: a session is a count of accepted frame bytes; everything follows from position.
  bit          m_live = 0;
  bit          m_busy, m_done, m_err, m_cpu_rst, m_we;
  int          m_pos, m_n, m_lo, m_sum, m_addr;
  logic [31:0] m_word, m_wdata;

  logic [31:0] wl_addr[$];
  logic [31:0] wl_data[$];

  function automatic bit m_ready();
    return m_busy && ((m_pos < 2) || (m_pos < 3 + 4 * m_n));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    if (Rst) begin
      m_live = 1; m_busy = 0; m_done = 0; m_err = 0; m_cpu_rst = 1; m_we = 0;
      m_pos = 0; m_n = 0; m_lo = 0; m_sum = 0; m_addr = 0; m_word = 0; m_wdata = 0;
    end else if (m_live) begin
      bit acc;
      acc  = Byte_valid && m_ready();
      m_we = 0;
      if (!m_busy && Start) begin
        m_busy = 1; m_done = 0; m_err = 0; m_cpu_rst = 1;
        m_pos = 0; m_sum = 0; m_word = 0;
      end else if (acc) begin
        if (m_pos == 0) begin
          m_lo = int'(Byte_in);
        end else if (m_pos == 1) begin
          m_n = m_lo + 256 * int'(Byte_in);
          if (m_n == 0 || m_n > MAXW) begin
            m_err = 1; m_busy = 0; m_cpu_rst = 1;
          end
        end else if (m_pos < 2 + 4 * m_n) begin
          int idx;
          idx   = m_pos - 2;
          m_sum = (m_sum + int'(Byte_in)) % 256;
          m_word[8 * (idx % 4) +: 8] = Byte_in;
          if (idx % 4 == 3) begin
            m_we = 1; m_addr = idx / 4; m_wdata = m_word; m_word = 0;
          end
        end else begin
          m_busy = 0;
          if (int'(Byte_in) == m_sum) begin
            m_done = 1; m_cpu_rst = 0;
          end else begin
            m_err = 1; m_cpu_rst = 1;
          end
        end
        m_pos++;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_live) begin
      cmp("Byte_ready", 32'(Byte_ready), 32'(m_ready()));
      cmp("Imem_we",    32'(Imem_we),    32'(m_we && !Rst));
      cmp("Imem_addr",  32'(Imem_addr),  32'(m_addr % (1 << AW)));
      cmp("Imem_wdata", Imem_wdata,      m_wdata);
      cmp("Cpu_rst",    32'(Cpu_rst),    32'(m_cpu_rst));
      cmp("Busy",       32'(Busy),       32'(m_busy));
      cmp("Done",       32'(Done),       32'(m_done));
      cmp("Error",      32'(Error),      32'(m_err));
      if (Imem_we === 1'b1) begin
        wl_addr.push_back(32'(Imem_addr));
        wl_data.push_back(Imem_wdata);
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  // stall: 0 none, 1 one idle cycle after each byte, 2 random 0..3 idle cycles
  task automatic send(input logic [7:0] b, input int stall, input bit noise);
    int g;
    g = 0;
    Byte_in    = b;
    Byte_valid = 1'b1;
    while (Byte_ready !== 1'b1 && g < 16) begin
      tick();
      g++;
    end
    checks++;
    if (Byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: Byte_ready got %b expected 1 for byte %h", Byte_ready, b);
    end
    if (noise && $urandom_range(0, 7) == 0) Start = 1'b1;
    tick();
    Byte_valid = 1'b0;
    Start      = 1'b0;
    if (stall == 1) tick();
    else if (stall == 2) repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int stall, input bit noise);
    foreach (fr[i]) send(fr[i], stall, noise);
  endtask

  task automatic expect_writes(input string name, input logic [31:0] a[$], input logic [31:0] d[$]);
    cmp({name, "_nwrites"}, 32'(wl_addr.size()), 32'(a.size()));
    if (wl_addr.size() == a.size()) begin
      foreach (a[i]) begin
        cmp({name, "_addr"}, wl_addr[i], a[i]);
        cmp({name, "_data"}, wl_data[i], d[i]);
      end
    end
  endtask

  task automatic expect_flags(input string name, input bit dn, input bit er, input bit bs, input bit cr);
    cmp({name, "_Done"},    32'(Done),    32'(dn));
    cmp({name, "_Error"},   32'(Error),   32'(er));
    cmp({name, "_Busy"},    32'(Busy),    32'(bs));
    cmp({name, "_Cpu_rst"}, 32'(Cpu_rst), 32'(cr));
  endtask

  logic [7:0]  f1[$];
  logic [7:0]  fr[$];
  logic [31:0] ea[$];
  logic [31:0] ed[$];

  initial begin
    Rst = 1'b1; Start = 1'b0; Byte_valid = 1'b0; Byte_in = 8'h00;
    tick(); tick();
    Rst = 1'b0;

    // Reset state
    expect_flags("reset", 0, 0, 0, 1);
    cmp("reset_ready", 32'(Byte_ready), 0);
    cmp("reset_we",    32'(Imem_we),    0);
    cmp("reset_addr",  32'(Imem_addr),  0);
    cmp("reset_wdata", Imem_wdata,      0);

    // Nominal load; CPU reset drops exactly on the checksum accept
    f1 = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    ea = '{32'd0, 32'd1};
    ed = '{32'hDEADBEEF, 32'h12345678};
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    expect_flags("start1", 0, 0, 1, 1);
    send_frame(f1, 0, 0);
    cmp("pre_check_Cpu_rst", 32'(Cpu_rst), 1);
    send(8'h4C, 0, 0);
    expect_writes("nominal", ea, ed);
    expect_flags("nominal", 1, 0, 0, 0);

    // Bad checksum
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    send_frame(f1, 0, 0);
    send(8'h4D, 0, 0);
    expect_writes("badsum", ea, ed);
    expect_flags("badsum", 0, 1, 0, 1);

    // Header bounds
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    send(8'h00, 0, 0); send(8'h00, 0, 0);
    expect_flags("hdr0", 0, 1, 0, 1);
    cmp("hdr0_nwrites", 32'(wl_addr.size()), 0);
    start_pulse();
    send(8'h01, 0, 0); send(8'h01, 0, 0);
    expect_flags("hdr257", 0, 1, 0, 1);
    start_pulse();
    send(8'h00, 0, 0); send(8'h01, 0, 0);
    expect_flags("hdr256", 0, 0, 1, 1);
    cmp("hdr256_ready", 32'(Byte_ready), 1);
    do_reset();

    // Stalled stream, then ignored bytes while DONE
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    send_frame(f1, 1, 0);
    send(8'h4C, 1, 0);
    expect_writes("stall", ea, ed);
    expect_flags("stall", 1, 0, 0, 0);
    Byte_in = 8'h02; Byte_valid = 1'b1;
    cmp("done_ready", 32'(Byte_ready), 0);
    tick(); tick();
    Byte_valid = 1'b0;
    expect_flags("done_ignore", 1, 0, 0, 0);

    // Reset mid-load after 5 data bytes
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    for (int i = 0; i < 7; i++) send(f1[i], 0, 0);
    do_reset();
    expect_flags("midrst", 0, 0, 0, 1);
    cmp("midrst_addr",  32'(Imem_addr), 0);
    cmp("midrst_wdata", Imem_wdata,     0);
    repeat (4) tick();
    cmp("midrst_nwrites", 32'(wl_addr.size()), 1);
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    send_frame(f1, 0, 0);
    send(8'h4C, 0, 0);
    expect_writes("after_rst", ea, ed);
    expect_flags("after_rst", 1, 0, 0, 0);

    // Re-load from DONE
    wl_addr.delete(); wl_data.delete();
    start_pulse();
    expect_flags("reload_start", 0, 0, 1, 1);
    fr = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame(fr, 0, 0);
    ea = '{32'd0};
    ed = '{32'h00000013};
    expect_writes("reload", ea, ed);
    expect_flags("reload", 1, 0, 0, 0);

    // Random frames with stalls, stray Start, stray bytes between sessions
    for (int k = 0; k < 10; k++) begin
      int n, s;
      n = $urandom_range(1, 6);
      s = 0;
      fr.delete();
      fr.push_back(8'(n)); fr.push_back(8'h00);
      for (int j = 0; j < 4 * n; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        s = (s + int'(b)) % 256;
        fr.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) s = (s + 1) % 256;
      fr.push_back(8'(s));
      Byte_in = 8'($urandom); Byte_valid = 1'b1;
      tick();
      Byte_valid = 1'b0;
      start_pulse();
      send_frame(fr, 2, 1);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
